reg_bus_arb: RTL and testbench
==============================

// Module: reg_bus_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing the single register bus (reg_op/reg_addr/
//  reg_wdata/reg_rdata) of the register block between NREQ requesters.
//  Accepts one request at a time and drives exactly one bus op per transaction.
//  Returns read data, or a write ack, to the granted requester.
//  Sits between the bus masters and the register block.
// PARAMETERS
//  NREQ    2  number of requesters (>=2)
//  DWIDTH  8  register data width
//  AWIDTH  8  register address width
// PORTS
//  clk         in   1            clock, all state on posedge
//  rst_n       in   1            async reset, active-low
//  req_valid   in   NREQ         requester i has a pending request
//  req_ready   out  NREQ         one-hot accept; transfer when valid&ready
//  req_op      in   NREQ*2       per-requester op (reg_bus_if encoding), slice i=[2i+1:2i]
//  req_addr    in   NREQ*AWIDTH  per-requester address
//  req_wdata   in   NREQ*DWIDTH  per-requester write data
//  rsp_valid   out  NREQ         one-hot, 1-cycle completion pulse to originator
//  rsp_err     out  1            qualifies rsp_valid: request op was not RD/WR
//  rsp_rdata   out  DWIDTH       read data; 0 for WR or err completions
//  reg_op      out  2            bus op to register block
//  reg_addr    out  AWIDTH       bus address
//  reg_wdata   out  DWIDTH       bus write data
//  reg_rdata   in   DWIDTH       bus read data, valid the cycle after a RD op
// BEHAVIOUR
//  Encoding (reg_bus_if): NOP=2'b00, RD=2'b01, WR=2'b10; 2'b11 illegal.
//  Reset (async assert, sync deassert): FSM=IDLE, rr pointer=NREQ-1, req_ready=0,
//   rsp_valid=0, rsp_err=0, rsp_rdata=0, reg_op=NOP, reg_addr=0, reg_wdata=0.
//  FSM states: IDLE, ISSUE, WAIT, RESP. Only one transaction in flight.
//  IDLE: req_ready combinational. The grant goes to the first i with req_valid[i],
//   searching ptr+1, ptr+2, ... mod NREQ. No valid means req_ready=0.
//   On valid&ready: latch op/addr/wdata and grant index, and set ptr=granted index.
//   Legal op -> ISSUE; illegal op -> RESP with err=1, bus untouched.
//  ISSUE (1 cycle): reg_op=latched op, reg_addr/reg_wdata=latched values.
//   RD -> WAIT; WR -> RESP.
//  WAIT (1 cycle): reg_op=NOP; capture reg_rdata at the end of this cycle -> RESP.
//  RESP (1 cycle): rsp_valid[grant]=1, rsp_err, rsp_rdata (registered) -> IDLE.
//  reg_op=NOP in every state except ISSUE. reg_addr/reg_wdata hold their last value.
//  Latency from accept edge: WR ack 2 cycles, RD data 3 cycles.
//   Min spacing is 3 cycles/WR and 4 cycles/RD.
//  req_ready=0 in ISSUE/WAIT/RESP. Requesters hold valid and fields stable until accepted.
//  A request dropped before acceptance is legal and is simply never granted.
//  Simultaneous valids: strict round-robin. No requester waits more than NREQ-1 grants.
//  rr pointer wraps NREQ-1 -> 0.
//  rsp_valid and req_ready are never both high for the same index in the same cycle.
//  A reset mid-transaction aborts it: no rsp is issued, and no bus op follows reset.
//   If the abort lands in ISSUE, the bus op may or may not have completed.
// TESTING
//  Reset: rst_n=0 mid-ISSUE -> all outputs zero/NOP at once; no rsp after release.
//  Single WR: req0 WR addr 8'h01 data 8'hA5 -> reg_op=WR one cycle later, rsp_valid[0]
//   two cycles after accept, rsp_err=0, rsp_rdata=0.
//  RD after WR: req1 RD addr 8'h01 -> rsp_valid[1] 3 cycles after accept, rsp_rdata=8'hA5.
//  Contention: req0 and req1 both valid continuously, from reset -> grants 0,1,0,1.
//   Each grant is preceded by rsp of the previous one; reg_op never two ops back-to-back.
//  Illegal op: req0 op=2'b11 -> accepted, reg_op stays NOP, rsp_valid[0]&rsp_err one
//   cycle after accept.
//  Idle bus: no req_valid for 20 cycles -> reg_op=NOP, req_ready=0, rsp_valid=0 throughout.

Source files
------------

// File: rtl/reg_bus_arb.sv
// reg_bus_arb: round-robin arbiter that sequences NREQ requesters onto one register bus
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             per-requester handshake (ready one-hot, combinational in IDLE)
//   req_op/req_addr/req_wdata       per-requester op, address and write data (slice i)
//   rsp_valid/rsp_err/rsp_rdata     one-cycle completion pulse to the granted requester
//   reg_op/reg_addr/reg_wdata       register-block bus, reg_rdata returned the cycle after RD
module reg_bus_arb #(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*2-1:0]        req_op,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic                     rsp_err,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic [1:0]               reg_op,
  output logic [AWIDTH-1:0]        reg_addr,
  output logic [DWIDTH-1:0]        reg_wdata,
  input  logic [DWIDTH-1:0]        reg_rdata
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t              r_state, w_next;
  logic [IW-1:0]       r_ptr, r_gnt, w_gnt, w_idx;
  logic                w_any, w_acc, w_legal, r_err;
  logic [1:0]          w_op, r_op;
  logic [AWIDTH-1:0]   w_addr, r_addr;
  logic [DWIDTH-1:0]   w_wdata, r_wdata, r_rdata;
  // Scan from the farthest offset down so the nearest valid after r_ptr wins.
  always_comb begin
    w_any   = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
    w_op    = OP_NOP;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == IW'(i)) begin
        w_op    = req_op[2*i +: 2];
        w_addr  = req_addr[i*AWIDTH +: AWIDTH];
        w_wdata = req_wdata[i*DWIDTH +: DWIDTH];
      end
    end
  end
  assign w_acc   = (r_state == IDLE) && w_any;
  assign w_legal = (w_op == OP_RD) || (w_op == OP_WR);
  // rst_n gating keeps ready low while reset is held even if requesters are valid.
  assign req_ready = (w_acc && rst_n) ? NREQ'(1) << w_gnt : '0;
  assign rsp_valid = (r_state == RESP) ? NREQ'(1) << r_gnt : '0;
  assign rsp_err   = (r_state == RESP) && r_err;
  assign rsp_rdata = (r_state == RESP) ? r_rdata : '0;
  assign reg_op    = (r_state == ISSUE) ? r_op : OP_NOP;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = w_legal ? ISSUE : RESP;
      ISSUE:   w_next = (r_op == OP_RD) ? WAIT : RESP;
      WAIT:    w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // Bus address/data only load for legal ops so an illegal request leaves the bus untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= IW'(NREQ - 1);
      r_gnt   <= '0;
      r_op    <= OP_NOP;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_acc) begin
        r_ptr   <= w_gnt;
        r_gnt   <= w_gnt;
        r_err   <= !w_legal;
        r_rdata <= '0;
        if (w_legal) begin
          r_op    <= w_op;
          r_addr  <= w_addr;
          r_wdata <= w_wdata;
        end
      end
      if (r_state == WAIT) r_rdata <= reg_rdata;
    end
  end
endmodule

// File: tb/tb_reg_bus_arb.sv
// tb_reg_bus_arb: scoreboard bench for reg_bus_arb with a register-block model and round-robin reference
module tb_reg_bus_arb;
  localparam int NREQ = 2;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_ready;
  logic [3:0]  req_op = '0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_rdata, reg_addr, reg_wdata;
  logic [1:0]  reg_op;
  logic [7:0]  reg_rdata = '0;
  always #5 clk = ~clk;
  reg_bus_arb #(.NREQ(NREQ), .DWIDTH(8), .AWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .reg_op(reg_op), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );
  typedef struct {int c; logic [1:0] op; logic [7:0] a; logic [7:0] d;} bus_t;
  typedef struct {int c; int g; logic err; logic [7:0] rd;} rsp_t;
  bus_t bq[$];
  rsp_t rq[$];
  bus_t mb;
  rsp_t mr;
  int nchk = 0, nerr = 0, cyc = 0, mptr = NREQ - 1, free_at = 0;
  logic [1:0] acc = '0, prev_op = '0, exp_rdy;
  logic [7:0] last_rd = '0;
  logic       last_err = 1'b0;
  logic [7:0] bmem [256];
  logic [7:0] mmem [256];
  int grants[$];
  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Register block: writes land on the edge ending ISSUE, read data is valid only the cycle after RD.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_op == 2'b10) bmem[reg_addr] <= reg_wdata;
    reg_rdata <= (reg_op == 2'b01) ? bmem[reg_addr] : 8'($urandom);
  end
  // Reference: round-robin pick, busy window per op type, expected bus op and response pushed on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      bq.delete();
      rq.delete();
      mptr = NREQ - 1;
      free_at = cyc;
      acc = '0;
    end else begin
      exp_rdy = '0;
      if (cyc >= free_at)
        for (int k = 1; k <= NREQ; k++) begin
          int j;
          j = (mptr + k) % NREQ;
          if (req_valid[j]) begin
            exp_rdy[j] = 1'b1;
            break;
          end
        end
      chk(req_ready == exp_rdy, "req_ready", req_ready, exp_rdy);
      acc = req_valid & req_ready;
      if (acc != 0) begin
        int g, lat;
        logic [1:0] op;
        logic [7:0] a, d, rd;
        logic legal;
        g = acc[0] ? 0 : 1;
        op = req_op[2*g +: 2];
        a = req_addr[8*g +: 8];
        d = req_wdata[8*g +: 8];
        legal = (op == 2'b01) || (op == 2'b10);
        lat = !legal ? 1 : (op == 2'b10) ? 2 : 3;
        rd = (legal && op == 2'b01) ? mmem[a] : 8'h00;
        if (legal && op == 2'b10) mmem[a] = d;
        if (legal) bq.push_back('{cyc + 1, op, a, d});
        rq.push_back('{cyc + lat, g, !legal, rd});
        mptr = g;
        free_at = cyc + lat + 1;
      end
    end
  end
  // Monitor: pops the scoreboard whenever the DUT drives a bus op or a response.
  always @(negedge clk) begin
    if (!rst_n) prev_op = '0;
    else begin
      if (reg_op != 2'b00) begin
        chk(prev_op == 2'b00, "bus_back_to_back", prev_op, 0);
        if (bq.size() == 0) chk(1'b0, "bus_unexpected", reg_op, 0);
        else begin
          mb = bq.pop_front();
          chk(cyc == mb.c, "bus_cycle", cyc, mb.c);
          chk({reg_op, reg_addr, reg_wdata} == {mb.op, mb.a, mb.d}, "bus_op_addr_data",
              {reg_op, reg_addr, reg_wdata}, {mb.op, mb.a, mb.d});
        end
      end
      prev_op = reg_op;
      chk((rsp_valid & req_ready) == 0, "ready_rsp_overlap", {rsp_valid, req_ready}, 0);
      if (rsp_valid != 0) begin
        if (rq.size() == 0) chk(1'b0, "rsp_unexpected", rsp_valid, 0);
        else begin
          mr = rq.pop_front();
          chk(cyc == mr.c, "rsp_cycle", cyc, mr.c);
          chk({rsp_valid, rsp_err, rsp_rdata} == {2'(1) << mr.g, mr.err, mr.rd}, "rsp_fields",
              {rsp_valid, rsp_err, rsp_rdata}, {2'(1) << mr.g, mr.err, mr.rd});
          last_rd = rsp_rdata;
          last_err = rsp_err;
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    req_valid[i] = v;
    req_op[2*i +: 2] = op;
    req_addr[8*i +: 8] = a;
    req_wdata[8*i +: 8] = d;
  endtask
  task automatic rnd_req(input int i, input bit any_op);
    int r;
    logic [1:0] op;
    r = $urandom % 10;
    op = (any_op && r == 0) ? 2'b11 : (any_op && r == 1) ? 2'b00 : ($urandom % 2 == 0) ? 2'b01 : 2'b10;
    set_req(i, 1'b1, op, 8'($urandom % 8), 8'($urandom));
  endtask
  task automatic drain;
    for (int n = 0; n < 10 && rq.size() != 0; n++) tick();
    chk(rq.size() == 0, "rsp_timeout", rq.size(), 0);
  endtask
  task automatic do_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    tick();
    set_req(i, 1'b1, op, a, d);
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = acc[i];
    end
    chk(got, "accept_timeout", got, 1);
    req_valid[i] = 1'b0;
    drain();
  endtask
  task automatic reset_chk(input string nm);
    chk({reg_op, reg_addr, reg_wdata, req_ready, rsp_valid, rsp_err, rsp_rdata} == 0, nm,
        {reg_op, reg_addr, reg_wdata, req_ready, rsp_valid, rsp_err, rsp_rdata}, 0);
  endtask
  initial begin
    bit got;
    for (int i = 0; i < 256; i++) begin
      bmem[i] = 8'h00;
      mmem[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_chk("reset_outputs");
    #2 rst_n = 1'b1;
    do_req(0, 2'b10, 8'h01, 8'hA5);
    do_req(1, 2'b01, 8'h01, 8'h00);
    chk(last_rd == 8'hA5, "rd_after_wr", last_rd, 8'hA5);
    do_req(0, 2'b11, 8'h05, 8'h33);
    chk(last_err == 1'b1, "illegal_err", last_err, 1);
    repeat (20) begin
      @(negedge clk);
      #1;
      chk({reg_op, req_ready, rsp_valid} == 0, "idle_bus", {reg_op, req_ready, rsp_valid}, 0);
    end
    tick();
    set_req(0, 1'b1, 2'b01, 8'h01, 8'h00);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = acc[0];
    end
    chk(got && reg_op == 2'b01, "issue_before_reset", reg_op, 1);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    reset_chk("reset_mid_issue");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    rnd_req(0, 1'b0);
    rnd_req(1, 1'b0);
    for (int n = 0; n < 60 && grants.size() < 4; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) begin
          grants.push_back(i);
          rnd_req(i, 1'b0);
        end
    end
    req_valid = '0;
    chk(grants.size() == 4, "contention_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk(grants[i] == i % 2, "contention_order", grants[i], i % 2);
    drain();
    for (int n = 0; n < 400; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || (req_valid[i] && $urandom % 16 == 0)) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom % 3 == 0) rnd_req(i, 1'b1);
      end
    end
    req_valid = '0;
    drain();
    tick();
    chk(bq.size() == 0, "bus_queue_empty", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
